// File: rtl/rtc_mux_bus_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_mux_bus_ctrl
// Transaction controller for the RTC multiplexed address/data tristate bus.
// One read or write request is accepted while idle; the controller then runs
// an address phase followed by a data phase, each made of setup, strobe and
// hold intervals. A recovery interval follows before the next accept.
//
// Optional build macro: RTC_MUX_BUS_BURST_EN
//   defined   : burst_len_i extra data beats follow a single address phase
//   undefined : burst_len_i is ignored, every transaction has one data beat
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   req_i        transaction request, sampled only while idle
//   wr_i         1 = write, 0 = read (latched at accept)
//   addr_i       RTC register address (latched at accept)
//   wdata_i      write data (latched at accept, and per beat in burst builds)
//   burst_len_i  extra data beats (burst builds only)
//   busy_o       high while a transaction is in progress
//   done_o       one-cycle pulse in the last hold cycle of each data beat
//   rdata_o      last read data, held until the next read beat
//   bus_ad_io    multiplexed address/data bus
//   cs_n_o       chip select, active low
//   ad_n_o       0 = address phase, 1 = data phase / idle
//   rd_n_o       read strobe, active low
//   wr_n_o       write strobe, active low
// ---------------------------------------------------------------------------
module rtc_mux_bus_ctrl #(
   parameter int DW    = 8,
   parameter int T_SU  = 2,
   parameter int T_PW  = 4,
   parameter int T_HD  = 2,
   parameter int T_REC = 2,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_i,
   input  logic          wr_i,
   input  logic [DW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [CW-1:0] burst_len_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] rdata_o,
   inout  wire  [DW-1:0] bus_ad_io,
   output logic          cs_n_o,
   output logic          ad_n_o,
   output logic          rd_n_o,
   output logic          wr_n_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A_SU = 3'd1,
      S_A_PW = 3'd2,
      S_A_HD = 3'd3,
      S_D_SU = 3'd4,
      S_D_PW = 3'd5,
      S_D_HD = 3'd6,
      S_REC  = 3'd7
   } state_t;

   // Counter reload values: a state loaded with T-1 and left at 0 lasts T cycles.
   localparam logic [CW-1:0] SU_LD    = CW'(T_SU - 1);
   localparam logic [CW-1:0] PW_LD    = CW'(T_PW - 1);
   localparam logic [CW-1:0] HD_LD    = CW'(T_HD - 1);
   localparam logic [CW-1:0] REC_LD   = CW'(T_REC - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_s;
   logic          wr_q, wr_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          cs_n_q, cs_n_d;
   logic          ad_n_q, ad_n_d;
   logic          rd_n_q, rd_n_d;
   logic          wr_n_q, wr_n_d;
   logic          oe_q, oe_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

`ifdef RTC_MUX_BUS_BURST_EN
   logic [CW-1:0] beats_q, beats_d;
`else
   logic          unused_burst_s;
   assign unused_burst_s = ^burst_len_i;
`endif

   assign last_s = (cnt_q == CNT_ZERO);

   // Next-state, interval counter and request latching.
   always_comb begin
      state_d = state_q;
      cnt_d   = last_s ? cnt_q : (cnt_q - CNT_ONE);
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef RTC_MUX_BUS_BURST_EN
      beats_d = beats_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               state_d = S_A_SU;
               cnt_d   = SU_LD;
               wr_d    = wr_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
`ifdef RTC_MUX_BUS_BURST_EN
               beats_d = burst_len_i;
`endif
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         S_A_SU: begin
            if (last_s) begin
               state_d = S_A_PW;
               cnt_d   = PW_LD;
            end else begin
               state_d = S_A_SU;
            end
         end
         S_A_PW: begin
            if (last_s) begin
               state_d = S_A_HD;
               cnt_d   = HD_LD;
            end else begin
               state_d = S_A_PW;
            end
         end
         S_A_HD: begin
            if (last_s) begin
               state_d = S_D_SU;
               cnt_d   = SU_LD;
            end else begin
               state_d = S_A_HD;
            end
         end
         S_D_SU: begin
            if (last_s) begin
               state_d = S_D_PW;
               cnt_d   = PW_LD;
            end else begin
               state_d = S_D_SU;
            end
         end
         S_D_PW: begin
            if (last_s) begin
               state_d = S_D_HD;
               cnt_d   = HD_LD;
            end else begin
               state_d = S_D_PW;
            end
         end
         S_D_HD: begin
            if (last_s) begin
`ifdef RTC_MUX_BUS_BURST_EN
               // Further beats reuse the address phase; the host has the next
               // write word on wdata_i by the done cycle, so sample it here.
               if (beats_q != CNT_ZERO) begin
                  state_d = S_D_SU;
                  cnt_d   = SU_LD;
                  beats_d = beats_q - CNT_ONE;
                  wdata_d = wdata_i;
               end else begin
                  state_d = S_REC;
                  cnt_d   = REC_LD;
               end
`else
               state_d = S_REC;
               cnt_d   = REC_LD;
`endif
            end else begin
               state_d = S_D_HD;
            end
         end
         S_REC: begin
            if (last_s) begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_REC;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Pin and status values derived from the next state so the registered
   // outputs line up with the state they belong to.
   always_comb begin
      cs_n_d = 1'b1;
      ad_n_d = 1'b1;
      rd_n_d = 1'b1;
      wr_n_d = 1'b1;
      oe_d   = 1'b0;
      dout_d = {DW{1'b0}};
      case (state_d)
         S_A_SU, S_A_HD: begin
            cs_n_d = 1'b0;
            ad_n_d = 1'b0;
            oe_d   = 1'b1;
            dout_d = addr_d;
         end
         S_A_PW: begin
            cs_n_d = 1'b0;
            ad_n_d = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            dout_d = addr_d;
         end
         S_D_SU, S_D_HD: begin
            cs_n_d = 1'b0;
            if (wr_d) begin
               oe_d   = 1'b1;
               dout_d = wdata_d;
            end else begin
               oe_d   = 1'b0;
            end
         end
         S_D_PW: begin
            cs_n_d = 1'b0;
            if (wr_d) begin
               wr_n_d = 1'b0;
               oe_d   = 1'b1;
               dout_d = wdata_d;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         S_IDLE, S_REC: begin
            cs_n_d = 1'b1;
         end
         default: begin
            cs_n_d = 1'b1;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_D_HD) && (cnt_d == CNT_ZERO);
   end

   // Read data is taken from the pins on the edge that ends the read strobe.
   always_comb begin
      if ((state_q == S_D_PW) && last_s && !wr_q) begin
         rdata_d = bus_ad_io;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // FSM state and interval counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
`ifdef RTC_MUX_BUS_BURST_EN
         beats_q <= CNT_ZERO;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef RTC_MUX_BUS_BURST_EN
         beats_q <= beats_d;
`endif
      end
   end

   // Latched request fields, read data and registered pin drivers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         addr_q  <= {DW{1'b0}};
         wdata_q <= {DW{1'b0}};
         rdata_q <= {DW{1'b0}};
         cs_n_q  <= 1'b1;
         ad_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         dout_q  <= {DW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cs_n_q  <= cs_n_d;
         ad_n_q  <= ad_n_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus_ad_io = oe_q ? dout_q : {DW{1'bz}};
   assign cs_n_o    = cs_n_q;
   assign ad_n_o    = ad_n_q;
   assign rd_n_o    = rd_n_q;
   assign wr_n_o    = wr_n_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_rtc_mux_bus_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for rtc_mux_bus_ctrl (default parameters).
// A cycle-indexed model gives the expected pin/status values relative to the
// accept cycle; completions are predicted into a scoreboard queue when a
// request is driven and popped when done_o is seen. While the controller is
// expected to release the bus, the bench drives a probe pattern onto it so a
// stray driver corrupts the value read back.
// ---------------------------------------------------------------------------
module tb_rtc_mux_bus_ctrl;

   localparam int SU  = 2;
   localparam int PW  = 4;
   localparam int HD  = 2;
   localparam int REC = 2;
   localparam int PH  = SU + PW + HD;

   typedef struct packed {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] rv;
      logic [3:0] bl;
   } vec_t;

   // ctl = {cs_n, ad_n, rd_n, wr_n, busy, done}; drv: 0 none, 1 addr, 2 data
   typedef struct packed {
      logic [5:0] ctl;
      logic [1:0] drv;
      logic [1:0] beat;
   } exp_t;

   typedef struct {
      int         k;
      logic [7:0] rd;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [3:0] burst_len = 4'h0;
   logic       busy, done, cs_n, ad_n, rd_n, wr_n;
   logic [7:0] rdata;
   wire  [7:0] bus_ad;

   logic       probe_en = 1'b1;
   logic [7:0] probe_val = 8'hC3;
   logic [7:0] rtc_val = 8'h00;
   logic [7:0] beat_d [4];
   logic [7:0] last_rd = 8'h00;
   sb_t        sbq[$];
   int         checks = 0;
   int         errors = 0;
   int         cur_k = 0;
   vec_t       vecs [8];
   vec_t       vnone;

   // RTC model answers while rd_n is low; otherwise the probe pattern.
   assign bus_ad = (rd_n == 1'b0) ? rtc_val : (probe_en ? probe_val : 8'hzz);

   always #5 clk = ~clk;

   rtc_mux_bus_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req),
      .wr_i        (wr),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .burst_len_i (burst_len),
      .busy_o      (busy),
      .done_o      (done),
      .rdata_o     (rdata),
      .bus_ad_io   (bus_ad),
      .cs_n_o      (cs_n),
      .ad_n_o      (ad_n),
      .rd_n_o      (rd_n),
      .wr_n_o      (wr_n)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %h, expected %h", nm, cur_k, act, exp);
      end
   endtask

   // Expected outputs in cycle k after the accept cycle (k=0).
   function automatic exp_t model(input int k, input logic w, input int nb);
      exp_t e;
      int   j;
      e.ctl  = 6'b111100;
      e.drv  = 2'd0;
      e.beat = 2'd0;
      if (k >= 1 && k <= PH + nb * PH + REC) e.ctl[1] = 1'b1;
      if (k >= 1 && k <= PH) begin
         e.ctl[5] = 1'b0;
         e.ctl[4] = 1'b0;
         e.drv    = 2'd1;
         if (k > SU && k <= SU + PW) e.ctl[2] = 1'b0;
      end else if (k > PH && k <= PH + nb * PH) begin
         j        = (k - PH - 1) % PH;
         e.beat   = 2'((k - PH - 1) / PH);
         e.ctl[5] = 1'b0;
         if (w) e.drv = 2'd2;
         if (j >= SU && j < SU + PW) begin
            if (w) e.ctl[2] = 1'b0;
            else   e.ctl[3] = 1'b0;
         end
         if (j == PH - 1) e.ctl[0] = 1'b1;
      end
      return e;
   endfunction

   task automatic push_beats(input logic w, input logic [7:0] rv, input int nb,
                             input int base, input int abort_k);
      sb_t s;
      for (int b = 0; b < nb; b++) begin
         s.k = base + PH + (b + 1) * PH;
         if (abort_k == 0 || s.k < abort_k) begin
            s.rd = w ? last_rd : rv;
            if (!w) last_rd = rv;
            sbq.push_back(s);
         end
      end
   endtask

   // Runs one transaction (or two back-to-back) starting at a negedge in IDLE.
   task automatic run_txn(input vec_t v, input vec_t v2, input int n_txn,
                          input int abort_k, input logic glitch, input logic own_beats);
      int         nb, nb2, occ, occ2, last;
      exp_t       e;
      logic [7:0] a_cur, d_cur, exp_bus;
      sb_t        s;
`ifdef RTC_MUX_BUS_BURST_EN
      nb  = int'(v.bl) + 1;
      nb2 = int'(v2.bl) + 1;
`else
      nb  = 1;
      nb2 = 1;
`endif
      occ  = PH + nb * PH + REC;
      occ2 = PH + nb2 * PH + REC;
      last = (n_txn == 2) ? (occ + 1 + occ2 + 1) : (occ + 1);
      if (!own_beats) for (int b = 0; b < 4; b++) beat_d[b] = v.d;
      req = 1'b1; wr = v.w; addr = v.a; wdata = v.d; burst_len = v.bl; rtc_val = v.rv;
      push_beats(v.w, v.rv, nb, 0, abort_k);
      for (int k = 1; k <= last; k++) begin
         @(posedge clk);
         #1;
         cur_k = k;
         if (n_txn == 2 && k > occ + 1) begin
            e     = model(k - (occ + 1), v2.w, nb2);
            a_cur = v2.a;
            d_cur = v2.d;
         end else begin
            e     = model(k, v.w, nb);
            a_cur = v.a;
            d_cur = beat_d[e.beat];
         end
         exp_bus   = (e.drv == 2'd1) ? a_cur : d_cur;
         probe_en  = (e.drv == 2'd0);
         probe_val = 8'hC3 ^ 8'(k);
         req       = (glitch && (k == 5 || k == 12)) || (n_txn == 2 && k <= occ + 1);
         wr = ~v.w; addr = ~v.a; wdata = ~v.d; burst_len = ~v.bl;
         if (k <= occ && e.ctl[0]) wdata = beat_d[(e.beat == 2'd3) ? 2'd3 : e.beat + 2'd1];
         if (n_txn == 2 && k == occ + 1) begin
            wr = v2.w; addr = v2.a; wdata = v2.d; burst_len = v2.bl; rtc_val = v2.rv;
            push_beats(v2.w, v2.rv, nb2, occ + 1, 0);
         end
         if (k == abort_k) begin
            probe_en = 1'b1;
            reset    = 1'b1;
            #1;
            chk("abort_pins", {26'd0, cs_n, ad_n, rd_n, wr_n, busy, done}, {26'd0, 6'b111100});
            chk("abort_rdata", {24'd0, rdata}, 32'd0);
            chk("abort_bus_z", {24'd0, bus_ad}, {24'd0, probe_val});
            last_rd = 8'h00;
            req     = 1'b0;
            @(negedge clk);
            chk("abort_hold_pins", {26'd0, cs_n, ad_n, rd_n, wr_n, busy, done}, {26'd0, 6'b111100});
            reset = 1'b0;
            chk("abort_sb_empty", 32'(sbq.size()), 32'd0);
            return;
         end
         @(negedge clk);
         chk("pins", {26'd0, cs_n, ad_n, rd_n, wr_n, busy, done}, {26'd0, e.ctl});
         if (e.drv != 2'd0)        chk("bus_drive", {24'd0, bus_ad}, {24'd0, exp_bus});
         else if (e.ctl[3] == 1'b0) chk("bus_rtc", {24'd0, bus_ad}, {24'd0, rtc_val});
         else                       chk("bus_z", {24'd0, bus_ad}, {24'd0, probe_val});
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
               s = sbq.pop_front();
               chk("done_cycle", k, s.k);
               chk("rdata", {24'd0, rdata}, {24'd0, s.rd});
            end
         end
      end
      req = 1'b0;
      chk("sb_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
`ifdef RTC_MUX_BUS_BURST_EN
      vec_t bv;
`endif
      vnone   = '0;
      vecs[0] = '{w: 1'b1, a: 8'h21, d: 8'h59, rv: 8'h00, bl: 4'd0};
      vecs[1] = '{w: 1'b0, a: 8'h24, d: 8'h00, rv: 8'hA7, bl: 4'd0};
      vecs[2] = '{w: 1'b0, a: 8'h5A, d: 8'h00, rv: 8'hA5, bl: 4'd0};
      vecs[3] = '{w: 1'b1, a: 8'hFF, d: 8'h00, rv: 8'h00, bl: 4'd0};
      vecs[4] = '{w: 1'b1, a: 8'h00, d: 8'hFF, rv: 8'h00, bl: 4'd0};
      vecs[5] = '{w: 1'b0, a: 8'h00, d: 8'h00, rv: 8'hFF, bl: 4'd0};
      vecs[6] = '{w: 1'b1, a: 8'h3C, d: 8'hC3, rv: 8'h00, bl: 4'd3};
      vecs[7] = '{w: 1'b0, a: 8'h81, d: 8'h00, rv: 8'h7E, bl: 4'd0};
      for (int b = 0; b < 4; b++) beat_d[b] = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      cur_k = 0;
      chk("reset_pins", {26'd0, cs_n, ad_n, rd_n, wr_n, busy, done}, {26'd0, 6'b111100});
      chk("reset_rdata", {24'd0, rdata}, 32'd0);
      chk("reset_bus_z", {24'd0, bus_ad}, {24'd0, probe_val});
      reset = 1'b0;
      @(negedge clk);

      // Table-driven single transactions
      for (int i = 0; i < 8; i++) run_txn(vecs[i], vnone, 1, 0, 1'b0, 1'b0);

      // Requests pulsed while busy are ignored
      run_txn('{w: 1'b1, a: 8'h42, d: 8'h6B, rv: 8'h00, bl: 4'd0}, vnone, 1, 0, 1'b1, 1'b0);

      // req held high: second accept right after recovery
      run_txn('{w: 1'b1, a: 8'h50, d: 8'h12, rv: 8'h00, bl: 4'd0},
              '{w: 1'b1, a: 8'h51, d: 8'h34, rv: 8'h00, bl: 4'd0}, 2, 0, 1'b0, 1'b0);

      // Reset in the data strobe of a write, then a normal transaction
      run_txn('{w: 1'b1, a: 8'h60, d: 8'h77, rv: 8'h00, bl: 4'd0}, vnone, 1, 12, 1'b0, 1'b0);
      run_txn('{w: 1'b1, a: 8'h61, d: 8'h88, rv: 8'h00, bl: 4'd0}, vnone, 1, 0, 1'b0, 1'b0);
      run_txn('{w: 1'b0, a: 8'h62, d: 8'h00, rv: 8'h96, bl: 4'd0}, vnone, 1, 0, 1'b0, 1'b0);

`ifdef RTC_MUX_BUS_BURST_EN
      // Three-beat write burst with distinct data per beat
      beat_d[0] = 8'h11; beat_d[1] = 8'h22; beat_d[2] = 8'h33; beat_d[3] = 8'h33;
      bv = '{w: 1'b1, a: 8'h30, d: 8'h11, rv: 8'h00, bl: 4'd2};
      run_txn(bv, vnone, 1, 0, 1'b0, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
